// File: rtl/conv2d_stream.sv
// rtl/conv2d_stream.sv - streaming 3x3 convolution with two line buffers, runtime kernel and saturating output
module conv2d_stream #(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int OUT_W  = 16,
    parameter int SHIFT  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_st,
    input  logic                     coef_wr,
    input  logic [3:0]               coef_addr,
    input  logic signed [COEF_W-1:0] coef_din,
    input  logic                     pix_valid,
    output logic                     pix_ready,
    input  logic signed [DATA_W-1:0] pix_din,
    output logic signed [OUT_W-1:0]  dout,
    output logic                     out_st,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done
);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int SUM_W  = PROD_W + 4;
    localparam int CW     = $clog2(IMG_W);
    localparam int RW     = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t state, state_nxt;

    logic [CW-1:0]            col;
    logic [RW-1:0]            row;
    logic signed [COEF_W-1:0] coef    [9];
    logic signed [DATA_W-1:0] line1   [IMG_W];
    logic signed [DATA_W-1:0] line2   [IMG_W];
    logic signed [DATA_W-1:0] win     [3][2];
    logic signed [DATA_W-1:0] new_col [3];
    logic signed [DATA_W-1:0] taps    [9];
    logic signed [PROD_W-1:0] prod_d  [9];
    logic signed [PROD_W-1:0] prod_q  [9];
    logic                     s1_valid, s1_last;
    logic signed [SUM_W-1:0]  sum, shifted;
    logic signed [OUT_W-1:0]  sat;
    logic                     stall, accept, at_last_pix, win_ok, last_beat, start;

    assign stall       = out_st && !out_ready;
    assign pix_ready   = (state == RUN) && !stall;
    assign accept      = pix_valid && pix_ready;
    assign at_last_pix = (col == COL_LAST) && (row == ROW_LAST);
    assign win_ok      = (row >= RW'(2)) && (col >= CW'(2));
    assign last_beat   = out_st && out_ready && out_last;
    assign start       = (state == IDLE) && in_st && !done;
    assign busy        = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (accept && at_last_pix) state_nxt = DRAIN;
            DRAIN:   if (last_beat) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) done <= 1'b0;
        else     done <= (state == DRAIN) && last_beat;
    end

    always_ff @(posedge clk) begin
        if (rst || start) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Reset kernel is the binomial blur: corners 1, edges 2, centre 4.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 9; k++)
                coef[k] <= COEF_W'((k == 4) ? 4 : ((k % 2) == 1) ? 2 : 1);
        end else if (state == IDLE && coef_wr && coef_addr < 4'd9) begin
            coef[coef_addr] <= coef_din;
        end
    end

    // The window keeps the two older columns; the newest column is read live
    // from the line buffers so the products see the pixel being accepted.
    always_comb begin
        new_col[0] = line2[col];
        new_col[1] = line1[col];
        new_col[2] = pix_din;
        for (int r = 0; r < 3; r++) begin
            taps[r*3+0] = win[r][0];
            taps[r*3+1] = win[r][1];
            taps[r*3+2] = new_col[r];
        end
        for (int k = 0; k < 9; k++)
            prod_d[k] = PROD_W'(taps[k]) * PROD_W'(coef[k]);
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            line2[col] <= line1[col];
            line1[col] <= pix_din;
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= new_col[r];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
        end else if (!stall) begin
            s1_valid <= accept && win_ok;
            s1_last  <= accept && at_last_pix;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) prod_q <= prod_d;
    end

    always_comb begin
        sum = '0;
        for (int k = 0; k < 9; k++)
            sum = sum + SUM_W'(prod_q[k]);
        shifted = sum >>> SHIFT;
    end

    generate
        if (OUT_W < SUM_W) begin : g_clip
            logic [SUM_W-OUT_W:0] hi;
            assign hi = shifted[SUM_W-1:OUT_W-1];
            // In range only when every bit above the output sign matches it.
            always_comb begin
                if (hi == '0 || hi == '1) sat = shifted[OUT_W-1:0];
                else                      sat = {shifted[SUM_W-1], {(OUT_W-1){~shifted[SUM_W-1]}}};
            end
        end else begin : g_wide
            assign sat = OUT_W'(shifted);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            out_st   <= 1'b0;
            out_last <= 1'b0;
            dout     <= '0;
        end else if (!stall) begin
            out_st   <= s1_valid;
            out_last <= s1_valid && s1_last;
            if (s1_valid) dout <= sat;
        end
    end
endmodule

// File: tb/tb_conv2d_stream.sv
// tb/tb_conv2d_stream.sv - table-driven and randomized frame checks against a behavioural 3x3 convolution model
module tb_conv2d_stream;
    localparam int W     = 8;
    localparam int H     = 8;
    localparam int N_PIX = W * H;
    localparam int N_RES = (W - 2) * (H - 2);

    logic clk = 1'b0;
    logic rst, in_st, coef_wr, pix_valid, out_ready;
    logic [3:0] coef_addr;
    logic signed [7:0] coef_din, pix_din;
    logic pr4, pr0, st4, st0, last4, last0, busy4, busy0, done4, done0;
    logic signed [15:0] d4, d0;

    conv2d_stream #(.IMG_W(W), .IMG_H(H), .DATA_W(8), .COEF_W(8), .OUT_W(16), .SHIFT(4)) u_dut (
        .clk(clk), .rst(rst), .in_st(in_st), .coef_wr(coef_wr), .coef_addr(coef_addr),
        .coef_din(coef_din), .pix_valid(pix_valid), .pix_ready(pr4), .pix_din(pix_din),
        .dout(d4), .out_st(st4), .out_ready(out_ready), .out_last(last4), .busy(busy4), .done(done4)
    );

    conv2d_stream #(.IMG_W(W), .IMG_H(H), .DATA_W(8), .COEF_W(8), .OUT_W(16), .SHIFT(0)) u_dut0 (
        .clk(clk), .rst(rst), .in_st(in_st), .coef_wr(coef_wr), .coef_addr(coef_addr),
        .coef_din(coef_din), .pix_valid(pix_valid), .pix_ready(pr0), .pix_din(pix_din),
        .dout(d0), .out_st(st0), .out_ready(out_ready), .out_last(last0), .busy(busy0), .done(done0)
    );

    always #5 clk = ~clk;

    typedef struct {
        int fill;      // 0 constant, 1 ramp 8r+c, 2 random
        int fval;
        int kid;       // 0 binomial, 1 identity, 2 all 127, 3 random, 4 binomial with centre 2
        int load;
        int bp;
        int guard;
        int start_wr;
        int abort_at;
        int chk;
        int e4_first;
        int e4_last;
        int e0_first;
        int e0_last;
    } vec_t;

    vec_t tbl [12];
    int   checks = 0;
    int   errors = 0;
    int   cur_frame = 0;
    int   frame [N_PIX];
    int   kern [9];
    int   q4 [$];
    int   q0 [$];

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s (frame %0d): got %0d expected %0d", name, cur_frame, got, exp);
        end
    endtask

    function automatic int sat16(input longint v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    function automatic void gen_kernel(input int kid);
        for (int i = 0; i < 9; i++) begin
            case (kid)
                0:       kern[i] = (i == 4) ? 4 : ((i % 2) == 1) ? 2 : 1;
                1:       kern[i] = (i == 4) ? 1 : 0;
                2:       kern[i] = 127;
                4:       kern[i] = ((i % 2) == 1 || i == 4) ? 2 : 1;
                default: kern[i] = int'($urandom_range(0, 255)) - 128;
            endcase
        end
    endfunction

    function automatic void build_model();
        q4.delete();
        q0.delete();
        for (int r = 2; r < H; r++) begin
            for (int c = 2; c < W; c++) begin
                longint s = 0;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        s += longint'(frame[(r - 2 + i) * W + (c - 2 + j)]) * longint'(kern[i * 3 + j]);
                q4.push_back(sat16(s >>> 4));
                q0.push_back(sat16(s));
            end
        end
    endfunction

    task automatic check_reset_outputs();
        check("rst_pix_ready", pr4, 0);   check("rst_pix_ready0", pr0, 0);
        check("rst_out_st", st4, 0);      check("rst_out_st0", st0, 0);
        check("rst_out_last", last4, 0);  check("rst_out_last0", last0, 0);
        check("rst_busy", busy4, 0);      check("rst_busy0", busy0, 0);
        check("rst_done", done4, 0);      check("rst_done0", done0, 0);
        check("rst_dout", int'(d4), 0);   check("rst_dout0", int'(d0), 0);
    endtask

    task automatic load_kernel(input int hold_center);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            coef_wr   = 1'b1;
            coef_addr = 4'(i);
            coef_din  = 8'((hold_center != 0 && i == 4) ? 0 : kern[i]);
        end
        @(negedge clk);
        coef_addr = 4'd12;
        coef_din  = 8'sd77;
        @(negedge clk);
        coef_wr = 1'b0;
    endtask

    task automatic run_frame(input vec_t v);
        int pidx = 0, ridx = 0, cyc = 0, acc22 = -1, first = -1, last_acc = -100;
        bit prev_stall = 1'b0, finished = 1'b0, aborted = 1'b0;
        int got4 [$];
        int got0 [$];

        for (int i = 0; i < N_PIX; i++)
            frame[i] = (v.fill == 0) ? v.fval : (v.fill == 1) ? (8 * (i / W) + (i % W))
                                              : int'($urandom_range(0, 255)) - 128;
        gen_kernel(v.kid);
        if (v.load != 0) load_kernel(v.start_wr);
        build_model();

        @(negedge clk);
        in_st = 1'b1;
        if (v.start_wr != 0) begin
            coef_wr   = 1'b1;
            coef_addr = 4'd4;
            coef_din  = 8'(kern[4]);
        end
        @(negedge clk);
        in_st   = 1'b0;
        coef_wr = 1'b0;
        check("busy_in_run", busy4, 1);

        while (!finished && cyc < 3000) begin
            out_ready = (v.bp != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pidx < N_PIX) begin
                pix_valid = (v.bp != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
                pix_din   = 8'(frame[pidx]);
            end else begin
                pix_valid = 1'b0;
            end
            if (v.guard != 0 && pidx < N_PIX) begin
                in_st     = (cyc % 5) == 3;
                coef_wr   = (cyc % 7) == 2;
                coef_addr = 4'd4;
                coef_din  = 8'sd99;
            end else begin
                in_st   = 1'b0;
                coef_wr = 1'b0;
            end
            #1;
            if (prev_stall) check("stall_hold_out_st", st4, 1);
            if (st4) begin
                if (ridx < N_RES) begin
                    check("dout_shift4", int'(d4), q4[ridx]);
                    check("dout_shift0", int'(d0), q0[ridx]);
                    check("out_last", last4, (ridx == N_RES - 1) ? 1 : 0);
                    check("out_last0", last0, (ridx == N_RES - 1) ? 1 : 0);
                    check("out_st0", st0, 1);
                end else begin
                    check("result_count_overrun", ridx + 1, N_RES);
                end
                if (out_ready) begin
                    got4.push_back(int'(d4));
                    got0.push_back(int'(d0));
                    if (first < 0) first = cyc;
                    if (last4) last_acc = cyc;
                    ridx++;
                    if (ridx == v.abort_at) aborted = 1'b1;
                end else begin
                    check("stall_pix_ready", pr4, 0);
                    check("stall_pix_ready0", pr0, 0);
                end
            end
            if (done4) begin
                check("done_timing", cyc, last_acc + 1);
                check("done0", done0, 1);
                in_st    = 1'b1;
                finished = 1'b1;
            end
            if (pix_valid && pr4) begin
                if (pidx == 2 * W + 2) acc22 = cyc;
                pidx++;
            end
            prev_stall = st4 && !out_ready;
            @(negedge clk);
            cyc++;
            if (aborted) begin
                rst       = 1'b1;
                pix_valid = 1'b0;
                in_st     = 1'b0;
                coef_wr   = 1'b0;
                out_ready = 1'b1;
                @(negedge clk);
                check_reset_outputs();
                rst = 1'b0;
                return;
            end
        end

        in_st = 1'b0;
        #1;
        check("frame_finished_in_budget", finished, 1);
        check("in_st_during_done_ignored", busy4, 0);
        check("done_single_cycle", done4, 0);
        check("result_count", ridx, N_RES);
        if (v.bp == 0) check("first_result_latency", first - acc22, 2);
        if (v.chk != 0 && got4.size() > 0) begin
            check("first_shift4", got4[0], v.e4_first);
            check("last_shift4", got4[got4.size() - 1], v.e4_last);
            check("first_shift0", got0[0], v.e0_first);
            check("last_shift0", got0[got0.size() - 1], v.e0_last);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{0, 16,   0, 0, 0, 0, 0, -1, 1, 16, 16, 256, 256};
        tbl[1]  = '{1, 0,    1, 1, 0, 0, 0, -1, 1, 0, 3, 9, 54};
        tbl[2]  = '{0, 127,  2, 1, 0, 0, 0, -1, 1, 9072, 9072, 32767, 32767};
        tbl[3]  = '{0, -128, 2, 1, 1, 0, 0, -1, 1, -9144, -9144, -32768, -32768};
        tbl[4]  = '{0, -1,   1, 1, 0, 0, 0, -1, 1, -1, -1, -1, -1};
        tbl[5]  = '{0, 16,   0, 1, 1, 0, 0, -1, 1, 16, 16, 256, 256};
        tbl[6]  = '{2, 0,    3, 1, 1, 0, 0, -1, 0, 0, 0, 0, 0};
        tbl[7]  = '{0, 16,   0, 1, 0, 1, 0, -1, 1, 16, 16, 256, 256};
        tbl[8]  = '{0, 16,   4, 1, 0, 0, 1, -1, 1, 14, 14, 224, 224};
        tbl[9]  = '{1, 0,    1, 1, 0, 0, 0, 10, 0, 0, 0, 0, 0};
        tbl[10] = '{0, 16,   0, 0, 0, 0, 0, -1, 1, 16, 16, 256, 256};
        tbl[11] = '{2, 0,    3, 1, 1, 1, 0, -1, 0, 0, 0, 0, 0};

        rst       = 1'b1;
        in_st     = 1'b0;
        coef_wr   = 1'b0;
        coef_addr = 4'd0;
        coef_din  = 8'sd0;
        pix_valid = 1'b0;
        pix_din   = 8'sd0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            cur_frame = i;
            run_frame(tbl[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/conv2d_stream.md
Name: conv2d_stream

Overview:
- Parametrised streaming 3x3 2D convolution engine.
- Accepts a raster-order pixel stream of an IMG_W x IMG_H frame through a valid/ready handshake and keeps two line buffers internally.
- Emits the (IMG_W-2) x (IMG_H-2) "valid" convolution results in raster order, with output backpressure.
- Kernel coefficients are runtime-loadable; results are shifted and saturated to OUT_W. It replaces the fixed 8x8 RAM-preload convolver in the image pipeline.

Parameters:
- IMG_W, 8, frame width in pixels (>=3).
- IMG_H, 8, frame height in lines (>=3).
- DATA_W, 8, signed pixel width.
- COEF_W, 8, signed coefficient width.
- OUT_W, 16, signed result width.
- SHIFT, 4, arithmetic right shift applied to the sum before saturation.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- in_st  in  1  frame start strobe; honoured only in IDLE.
- coef_wr  in  1  coefficient write enable; honoured only in IDLE.
- coef_addr  in  4  coefficient index 0..8, row-major (0 = top-left); 9..15 ignored.
- coef_din  in  COEF_W  signed coefficient value.
- pix_valid  in  1  input pixel valid.
- pix_ready  out  1  input pixel accepted when pix_valid && pix_ready.
- pix_din  in  DATA_W  signed pixel.
- dout  out  OUT_W  signed convolution result.
- out_st  out  1  dout valid.
- out_ready  in  1  downstream accepts dout when out_st && out_ready.
- out_last  out  1  high with the final result of the frame.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  one-cycle pulse after the last result is accepted.

Behaviour:
- Clock and reset: one clock, clk. Reset (rst) is synchronous and active-high.
- Reset values:
  - pix_ready=0, out_st=0, out_last=0, busy=0, done=0, dout=0.
  - State=IDLE; all counters and pipeline valids cleared.
  - Coefficients reset to the binomial kernel [1 2 1; 2 4 2; 1 2 1], which gives a 1/16 blur with SHIFT=4.
- Reset mid-frame: abandons the frame immediately; no done pulse; line-buffer contents are don't-care.
- IDLE state:
  - coef_wr writes coef_din into coefficient[coef_addr] on the same edge.
  - in_st moves to RUN and clears the column/row counters.
  - If coef_wr and in_st occur on the same cycle, the write takes effect and the frame uses the new value.
- RUN state:
  - pix_ready = !stall, where stall = out_st && !out_ready.
  - Each accepted pixel shifts into the line buffers and the 3x3 window, then advances col (wraps at IMG_W-1 and increments row).
  - in_st, coef_wr and coef_addr are ignored.
  - After the pixel at (IMG_W-1, IMG_H-1) is accepted, go to DRAIN.
- DRAIN state:
  - pix_ready=0; the pipeline empties.
  - When the last result is accepted (out_st && out_ready && out_last): pulse done, go to IDLE.
  - done and a new in_st may not overlap; in_st is honoured from the cycle after done.
- Window validity: the window is valid when the accepted pixel has row>=2 and col>=2. The result is for the window whose bottom-right corner is that pixel.
- Pipeline: 2 stages, both advancing only when !stall.
  - Stage 1 registers the 9 products, each DATA_W+COEF_W signed.
  - Stage 2 computes the sum at DATA_W+COEF_W+4 bits, applies an arithmetic shift right by SHIFT (truncation toward -inf), saturates to [-2^(OUT_W-1), 2^(OUT_W-1)-1], and registers the result into dout/out_st.
- Latency: dout appears 2 clk after the completing pixel is accepted, assuming no stall.
- Backpressure: while stall, dout, out_st and out_last hold stable and no pixel is accepted.
- Throughput: 1 result per clk in steady state.
- out_last is asserted with result index (IMG_W-2)*(IMG_H-2)-1.
- Per frame, exactly (IMG_W-2)*(IMG_H-2) results are produced.
- busy = (state != IDLE).

Test Plan:
- Default kernel, 8x8 frame, all pixels 16, out_ready=1 -> 36 results, each 256>>4 = 16. out_last on the 36th. done one cycle after. The first result appears 2 clk after pixel (2,2) is accepted.
- Load an identity kernel (coef[4]=1, all others 0) with SHIFT=0 parameterisation and ramp pixels p(r,c)=8r+c -> result(r,c) = 8(r+1)+(c+1), i.e. the sequence 9,10,...,14,17,..., 54.
- Saturation: coefficients all 127, pixels all 127, OUT_W=16, SHIFT=0 -> sum 145161 clips to 32767. Pixels all -128 -> sum -146304 clips to -32768.
- Backpressure: toggle out_ready in a pseudo-random 50% pattern -> the same 36 values in the same order, with no drops or duplicates. dout stays stable during every stalled cycle, and pix_ready stays low whenever out_st && !out_ready.
- Mode guards: coef_wr and in_st asserted mid-RUN -> the kernel and frame are unaffected. Then, on the same cycle in IDLE, coef_wr (addr 4 = 2) with in_st -> the new frame uses coef[4]=2.
- Reset at result 10 of 36 -> the next cycle has all outputs at reset values and the coefficients back to binomial. A fresh frame afterwards produces all 36 correct results.
